// File: rtl/cpu_pkg.sv
// cpu_pkg: shared execute-stage constants, shifter state and shift op encodings
package cpu_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} sr_state_t;
  localparam logic ALU_SRL = 1'b0;
  localparam logic ALU_SRA = 1'b1;
endpackage

// File: rtl/sr_step.sv
// sr_step: combinational right shift by up to STEP bits with a fill bit
module sr_step #(
  parameter int XLEN = 32,
  parameter int STEP = 4,
  localparam int AW = $clog2(STEP) + 1
) (
  input  logic [XLEN-1:0] acc,
  input  logic [AW-1:0]   amt,
  input  logic            fill,
  output logic [XLEN-1:0] res
);
  assign res = fill ? ~(~acc >> amt) : acc >> amt;
endmodule

// File: rtl/sr_iter.sv
// sr_iter: multi-cycle SRL/SRA shifter with start/ready/done handshake and flush
module sr_iter
  import cpu_pkg::*;
#(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int STEP = 4,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [SHW-1:0]  shamt_i,
  input  logic            arith_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int AW = $clog2(STEP) + 1;
  sr_state_t       state;
  logic [XLEN-1:0] acc, shifted;
  logic [SHW-1:0]  rem;
  logic            fill, last;
  logic [AW-1:0]   amt;
  assign last    = 32'(rem) <= STEP;
  assign amt     = last ? AW'(rem) : AW'(STEP);
  assign ready_o = rst_n && state == IDLE;
  assign busy_o  = state == SHIFT || state == DONE;
  assign done_o  = state == DONE;
  sr_step #(.XLEN(XLEN), .STEP(STEP)) u_step (
    .acc (acc),
    .amt (amt),
    .fill(fill),
    .res (shifted)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      rem      <= '0;
      fill     <= 1'b0;
      result_o <= '0;
    end else if (flush_i) begin
      state <= IDLE;
    end else if (state == IDLE && start_i) begin
      acc   <= data_i;
      rem   <= shamt_i;
      fill  <= arith_i & data_i[XLEN-1];
      state <= SHIFT;
    end else if (state == SHIFT) begin
      acc <= shifted;
      rem <= rem - SHW'(amt);
      if (last) begin
        state    <= DONE;
        result_o <= shifted;
      end
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_sr_iter.sv
// tb_sr_iter: directed stimulus with a latency/result model checked every cycle
module tb_sr_iter;
  logic        clk = 0, rst_n = 0, start_i = 0, arith_i = 0, flush_i = 0;
  logic [31:0] data_i = 0;
  logic [4:0]  shamt_i = 0;
  logic        ready_o, busy_o, done_o;
  logic [31:0] result_o;
  int checks = 0, failures = 0;
  int m_left = 0;
  bit m_dn = 0;
  logic [31:0] m_res = 0, m_pend = 0;

  sr_iter dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .data_i(data_i), .shamt_i(shamt_i),
    .arith_i(arith_i), .flush_i(flush_i), .ready_o(ready_o), .busy_o(busy_o),
    .done_o(done_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // model: result from plain shift operators, done after 1+max(1,ceil(shamt/4)) cycles
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_left = 0; m_dn = 0; m_res = 0;
    end else if (flush_i) begin
      m_left = 0; m_dn = 0;
    end else if (m_dn) begin
      m_dn = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_dn = 1; m_res = m_pend;
      end
    end else if (start_i) begin
      m_pend = arith_i ? 32'($signed(data_i) >>> shamt_i) : data_i >> shamt_i;
      m_left = shamt_i == 0 ? 1 : (int'(shamt_i) + 3) / 4;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("m_done", {31'b0, done_o}, {31'b0, m_dn});
    chk("m_ready", {31'b0, ready_o}, {31'b0, rst_n && m_left == 0 && !m_dn});
    chk("m_busy", {31'b0, busy_o}, {31'b0, m_left > 0 || m_dn});
    chk("m_result", result_o, m_res);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [31:0] d, input logic [4:0] s, input logic a);
    int n = 0;
    start_i = 1; data_i = d; shamt_i = s; arith_i = a;
    while (!ready_o && n < 50) begin
      tick(); n++;
    end
    tick();
    start_i = 0;
  endtask

  task automatic wait_done(input string name, input int exp_cyc, input logic [31:0] exp_res);
    int cyc = 1;
    while (!done_o && cyc < 60) begin
      tick(); cyc++;
    end
    chk({name, "_lat"}, 32'(cyc), 32'(exp_cyc));
    chk({name, "_res"}, result_o, exp_res);
  endtask

  initial begin
    tick(); tick();
    chk("rst_ready", {31'b0, ready_o}, 32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_result", result_o, 32'h0);
    rst_n = 1;
    tick();
    chk("rel_ready", {31'b0, ready_o}, 32'd1);
    go(32'hF000_0000, 5'd4, 1'b0);
    wait_done("srl4", 2, 32'h0F00_0000);
    go(32'h8000_0000, 5'd31, 1'b1);
    wait_done("sra31", 9, 32'hFFFF_FFFF);
    go(32'h8000_0000, 5'd31, 1'b0);
    wait_done("srl31", 9, 32'h0000_0001);
    go(32'h1234_5678, 5'd0, 1'b0);
    wait_done("sh0", 2, 32'h1234_5678);
    tick();
    chk("sh0_done_once", {31'b0, done_o}, 32'd0);
    chk("sh0_ready3", {31'b0, ready_o}, 32'd1);
    go(32'hDEAD_BEEF, 5'd20, 1'b1);
    tick(); tick();
    flush_i = 1;
    tick();
    flush_i = 0;
    chk("flush_ready", {31'b0, ready_o}, 32'd1);
    chk("flush_done", {31'b0, done_o}, 32'd0);
    chk("flush_result", result_o, 32'h1234_5678);
    flush_i = 1; start_i = 1; data_i = 32'hFFFF_FFFF; shamt_i = 5'd3;
    tick();
    flush_i = 0; start_i = 0;
    chk("flush_start_busy", {31'b0, busy_o}, 32'd0);
    chk("flush_start_ready", {31'b0, ready_o}, 32'd1);
    repeat (3) tick();
    start_i = 1; data_i = 32'hFFFF_0000; shamt_i = 5'd8; arith_i = 0;
    tick();
    data_i = 32'h8000_00F0; shamt_i = 5'd5; arith_i = 1;
    wait_done("b2b_a", 3, 32'h00FF_FF00);
    chk("b2b_bubble", {31'b0, ready_o}, 32'd0);
    tick();
    chk("b2b_ready", {31'b0, ready_o}, 32'd1);
    tick();
    start_i = 0;
    wait_done("b2b_b", 3, 32'hFC00_0007);
    tick();
    go(32'h8000_0000, 5'd31, 1'b1);
    repeat (4) tick();
    rst_n = 0;
    tick();
    chk("mid_rst_done", {31'b0, done_o}, 32'd0);
    chk("mid_rst_result", result_o, 32'h0);
    chk("mid_rst_busy", {31'b0, busy_o}, 32'd0);
    chk("mid_rst_ready", {31'b0, ready_o}, 32'd0);
    rst_n = 1;
    tick();
    chk("mid_rel_ready", {31'b0, ready_o}, 32'd1);
    repeat (12) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
